// File: rtl/gpu_pkg.sv
// Shared GPU definitions.
// Holds the scheduler state encoding, the default command width and the
// command opcode field layout. The register-file decoder uses the same
// opcode constants.
package gpu_pkg;

  localparam int CMD_W_DFLT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } sched_state_t;

  // Command word layout: [15:12] opcode, [11:0] operand.
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;

  localparam logic [3:0] OPC_NOP      = 4'h0;
  localparam logic [3:0] OPC_OBJ_POS  = 4'h1;
  localparam logic [3:0] OPC_OBJ_TILE = 4'h2;
  localparam logic [3:0] OPC_OBJ_ATTR = 4'h3;
  localparam logic [3:0] OPC_PALETTE  = 4'h4;

  function automatic logic [3:0] cmd_opcode(input logic [CMD_W_DFLT-1:0] cmd);
    return cmd[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/vblank_cmd_scheduler_cmd_fifo.sv
// cmd_fifo: synchronous circular command buffer with asynchronous reset.
// Ports:
//   clk, rst_n : clock, async active-low reset (clears storage too)
//   push, din  : write request and data; refused when full, even on a pop
//   pop        : remove the head entry (ignored when empty)
//   dout       : head entry mem[rd_ptr]
//   fill       : occupancy 0..DEPTH
//   ready      : not full
module cmd_fifo
  import gpu_pkg::*;
#(
  parameter int CMD_W  = CMD_W_DFLT,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [CMD_W-1:0]  din,
  input  logic              pop,
  output logic [CMD_W-1:0]  dout,
  output logic [ADDR_W:0]   fill,
  output logic              ready
);

  logic [CMD_W-1:0]  mem_q [DEPTH];
  logic [CMD_W-1:0]  mem_d [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   fill_q, fill_d;
  logic              push_ok;
  logic              pop_ok;

  assign ready   = (fill_q != (ADDR_W+1)'(DEPTH));
  assign push_ok = push & ready;
  assign pop_ok  = pop & (fill_q != '0);
  assign dout    = mem_q[rd_ptr_q];
  assign fill    = fill_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   fill_d = fill_q + (ADDR_W+1)'(1);
      2'b01:   fill_d = fill_q - (ADDR_W+1)'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

endmodule

// File: rtl/vblank_cmd_scheduler.sv
// vblank_cmd_scheduler: buffers host commands and releases them to the
// object register file only while cmd_en (vertical blank) is high, at most
// MAX_PER_FRAME writes per window.
// Ports:
//   clk, rst_n          : pixel clock, async active-low reset
//   cmd_en              : blanking window from the timing generator
//   in_valid, in_data   : host command input; in_ready = FIFO not full
//   wr_en, wr_data      : register-file write strobe and FIFO head word
//   frame_start         : one-cycle pulse after each cmd_en rising edge
//   frame_cnt           : windows entered, wraps at 255
//   fill                : FIFO occupancy
//   overrun             : sticky, a command was offered while full
//   backlog             : sticky, a window closed with commands left over
module vblank_cmd_scheduler
  import gpu_pkg::*;
#(
  parameter int CMD_W         = CMD_W_DFLT,
  parameter int DEPTH         = 4,
  parameter int ADDR_W        = 2,
  parameter int MAX_PER_FRAME = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_en,
  input  logic              in_valid,
  input  logic [CMD_W-1:0]  in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [CMD_W-1:0]  wr_data,
  output logic              frame_start,
  output logic [7:0]        frame_cnt,
  output logic [ADDR_W:0]   fill,
  output logic              overrun,
  output logic              backlog
);

  localparam logic [7:0] BUDGET_MAX = 8'(MAX_PER_FRAME);

  sched_state_t state_q, state_d;
  logic         cmd_en_q, cmd_en_d;
  logic [7:0]   budget_q, budget_d;
  logic         frame_start_q, frame_start_d;
  logic [7:0]   frame_cnt_q, frame_cnt_d;
  logic         overrun_q, overrun_d;
  logic         backlog_q, backlog_d;
  logic         rise;

  cmd_fifo #(
    .CMD_W  (CMD_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .din   (in_data),
    .pop   (wr_en),
    .dout  (wr_data),
    .fill  (fill),
    .ready (in_ready)
  );

  assign rise        = cmd_en & ~cmd_en_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;
  assign overrun     = overrun_q;
  assign backlog     = backlog_q;

  always_comb begin
    state_d       = state_q;
    cmd_en_d      = cmd_en;
    budget_d      = budget_q;
    frame_start_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    overrun_d     = overrun_q | (in_valid & ~in_ready);
    backlog_d     = backlog_q;
    wr_en         = 1'b0;

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d       = DRAIN;
          budget_d      = '0;
          frame_start_d = 1'b1;
          frame_cnt_d   = frame_cnt_q + 8'd1;
        end
      end
      DRAIN: begin
        wr_en = cmd_en & (fill != '0) & (budget_q < BUDGET_MAX);
        if (wr_en) budget_d = budget_q + 8'd1;
        // Leaving on cmd_en low means no pop this cycle, so fill is already
        // the post-pop occupancy.
        if (!cmd_en) begin
          state_d = IDLE;
          if (fill != '0) backlog_d = 1'b1;
        end else if (budget_d == BUDGET_MAX) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!cmd_en) begin
          state_d = IDLE;
          if (fill != '0) backlog_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // cmd_en_q resets high so a reset released mid-blank waits for the next
  // genuine rising edge instead of draining a partial window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cmd_en_q      <= 1'b1;
      budget_q      <= '0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
      overrun_q     <= 1'b0;
      backlog_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_en_q      <= cmd_en_d;
      budget_q      <= budget_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
      overrun_q     <= overrun_d;
      backlog_q     <= backlog_d;
    end
  end

endmodule

// File: tb/tb_vblank_cmd_scheduler.sv
module tb_vblank_cmd_scheduler;

  localparam int CMD_W         = 16;
  localparam int DEPTH         = 4;
  localparam int ADDR_W        = 2;
  localparam int MAX_PER_FRAME = 3;
  localparam int NVEC          = 31;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_en;
  logic              in_valid;
  logic [CMD_W-1:0]  in_data;
  logic              in_ready;
  logic              wr_en;
  logic [CMD_W-1:0]  wr_data;
  logic              frame_start;
  logic [7:0]        frame_cnt;
  logic [ADDR_W:0]   fill;
  logic              overrun;
  logic              backlog;

  vblank_cmd_scheduler #(
    .CMD_W         (CMD_W),
    .DEPTH         (DEPTH),
    .ADDR_W        (ADDR_W),
    .MAX_PER_FRAME (MAX_PER_FRAME)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_en      (cmd_en),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt),
    .fill        (fill),
    .overrun     (overrun),
    .backlog     (backlog)
  );

  always #5 clk = ~clk;

  // One record per clock: inputs for the cycle and outputs expected before
  // the closing edge. wd is checked only when the head is defined.
  typedef struct {
    int ce; int iv; int din;
    int we; int wd; int fill; int rdy; int fs; int fc; int bl; int ov;
  } vec_t;

  vec_t vecs[NVEC];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //           ce iv din      we wd       fill rdy fs fc bl ov
    vecs[0]  = '{1, 0, 0,       0, 0,       0,   1,  0, 0, 0, 0};
    vecs[1]  = '{1, 0, 0,       0, 0,       0,   1,  0, 0, 0, 0};
    vecs[2]  = '{0, 1, 'hA001,  0, 0,       0,   1,  0, 0, 0, 0};
    vecs[3]  = '{0, 1, 'hA002,  0, 'hA001,  1,   1,  0, 0, 0, 0};
    vecs[4]  = '{1, 0, 0,       0, 'hA001,  2,   1,  0, 0, 0, 0};
    vecs[5]  = '{1, 0, 0,       1, 'hA001,  2,   1,  1, 1, 0, 0};
    vecs[6]  = '{1, 0, 0,       1, 'hA002,  1,   1,  0, 1, 0, 0};
    vecs[7]  = '{1, 0, 0,       0, 0,       0,   1,  0, 1, 0, 0};
    vecs[8]  = '{1, 1, 'hB001,  0, 0,       0,   1,  0, 1, 0, 0};
    vecs[9]  = '{1, 0, 0,       1, 'hB001,  1,   1,  0, 1, 0, 0};
    vecs[10] = '{1, 0, 0,       0, 0,       0,   1,  0, 1, 0, 0};
    vecs[11] = '{0, 0, 0,       0, 0,       0,   1,  0, 1, 0, 0};
    vecs[12] = '{0, 1, 'hC001,  0, 0,       0,   1,  0, 1, 0, 0};
    vecs[13] = '{0, 1, 'hC002,  0, 'hC001,  1,   1,  0, 1, 0, 0};
    vecs[14] = '{0, 1, 'hC003,  0, 'hC001,  2,   1,  0, 1, 0, 0};
    vecs[15] = '{0, 1, 'hC004,  0, 'hC001,  3,   1,  0, 1, 0, 0};
    vecs[16] = '{0, 1, 'hDEAD,  0, 'hC001,  4,   0,  0, 1, 0, 0};
    vecs[17] = '{0, 0, 0,       0, 'hC001,  4,   0,  0, 1, 0, 1};
    vecs[18] = '{1, 0, 0,       0, 'hC001,  4,   0,  0, 1, 0, 1};
    vecs[19] = '{1, 1, 'hEEEE,  1, 'hC001,  4,   0,  1, 2, 0, 1};
    vecs[20] = '{1, 0, 0,       1, 'hC002,  3,   1,  0, 2, 0, 1};
    vecs[21] = '{1, 1, 'hC005,  1, 'hC003,  2,   1,  0, 2, 0, 1};
    vecs[22] = '{1, 0, 0,       0, 'hC004,  2,   1,  0, 2, 0, 1};
    vecs[23] = '{1, 0, 0,       0, 'hC004,  2,   1,  0, 2, 0, 1};
    vecs[24] = '{0, 0, 0,       0, 'hC004,  2,   1,  0, 2, 0, 1};
    vecs[25] = '{0, 0, 0,       0, 'hC004,  2,   1,  0, 2, 1, 1};
    vecs[26] = '{1, 0, 0,       0, 'hC004,  2,   1,  0, 2, 1, 1};
    vecs[27] = '{1, 0, 0,       1, 'hC004,  2,   1,  1, 3, 1, 1};
    vecs[28] = '{1, 0, 0,       1, 'hC005,  1,   1,  0, 3, 1, 1};
    vecs[29] = '{0, 0, 0,       0, 0,       0,   1,  0, 3, 1, 1};
    vecs[30] = '{0, 0, 0,       0, 0,       0,   1,  0, 3, 1, 1};

    // Reset held 3 cycles with cmd_en high.
    rst_n    = 1'b0;
    cmd_en   = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset wr_en",     int'(wr_en),     0);
    chk("reset wr_data",   int'(wr_data),   0);
    chk("reset fill",      int'(fill),      0);
    chk("reset in_ready",  int'(in_ready),  1);
    chk("reset frame_cnt", int'(frame_cnt), 0);
    chk("reset frame_st",  int'(frame_start), 0);
    chk("reset overrun",   int'(overrun),   0);
    chk("reset backlog",   int'(backlog),   0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      cmd_en   = vecs[i].ce[0];
      in_valid = vecs[i].iv[0];
      in_data  = vecs[i].din[CMD_W-1:0];
      @(negedge clk);
      chk($sformatf("vec%0d wr_en", i),       int'(wr_en),       vecs[i].we);
      chk($sformatf("vec%0d fill", i),        int'(fill),        vecs[i].fill);
      chk($sformatf("vec%0d in_ready", i),    int'(in_ready),    vecs[i].rdy);
      chk($sformatf("vec%0d frame_start", i), int'(frame_start), vecs[i].fs);
      chk($sformatf("vec%0d frame_cnt", i),   int'(frame_cnt),   vecs[i].fc);
      chk($sformatf("vec%0d backlog", i),     int'(backlog),     vecs[i].bl);
      chk($sformatf("vec%0d overrun", i),     int'(overrun),     vecs[i].ov);
      if (vecs[i].we != 0 || vecs[i].fill != 0)
        chk($sformatf("vec%0d wr_data", i),   int'(wr_data),     vecs[i].wd);
      tick();
    end

    // Reset asserted in the middle of a drain with three commands queued.
    cmd_en   = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'hE001; tick();
    in_data  = 16'hE002; tick();
    in_data  = 16'hE003; tick();
    in_valid = 1'b0;
    cmd_en   = 1'b1;
    tick();
    @(negedge clk);
    chk("middrain wr_en",   int'(wr_en),   1);
    chk("middrain wr_data", int'(wr_data), 'hE001);
    chk("middrain fill",    int'(fill),    3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst wr_en",     int'(wr_en),       0);
    chk("async rst fill",      int'(fill),        0);
    chk("async rst overrun",   int'(overrun),     0);
    chk("async rst backlog",   int'(backlog),     0);
    chk("async rst frame_cnt", int'(frame_cnt),   0);
    chk("async rst frame_st",  int'(frame_start), 0);
    chk("async rst wr_data",   int'(wr_data),     0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("post rst held cmd_en wr_en %0d", k), int'(wr_en), 0);
      chk($sformatf("post rst held frame_cnt %0d", k), int'(frame_cnt), 0);
      tick();
    end

    // Window only one cycle long: no write, backlog raised.
    cmd_en   = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'hF001; tick();
    in_data  = 16'hF002; tick();
    in_data  = 16'hF003; tick();
    in_valid = 1'b0;
    cmd_en   = 1'b1;
    @(negedge clk);
    chk("short rise wr_en",   int'(wr_en),   0);
    chk("short rise fill",    int'(fill),    3);
    chk("short rise wr_data", int'(wr_data), 'hF001);
    chk("short rise backlog", int'(backlog), 0);
    tick();
    cmd_en = 1'b0;
    @(negedge clk);
    chk("short fall wr_en",     int'(wr_en),       0);
    chk("short fall frame_st",  int'(frame_start), 1);
    chk("short fall frame_cnt", int'(frame_cnt),   1);
    tick();
    @(negedge clk);
    chk("short after wr_en",    int'(wr_en),       0);
    chk("short after backlog",  int'(backlog),     1);
    chk("short after fill",     int'(fill),        3);
    chk("short after frame_st", int'(frame_start), 0);
    tick();

    // 255 further windows: frame_cnt goes 1 -> 255 -> 0.
    for (int k = 0; k < 255; k++) begin
      cmd_en = 1'b1;
      tick();
      cmd_en = 1'b0;
      tick();
      chk($sformatf("wrap frame_cnt %0d", k), int'(frame_cnt), (k + 2) % 256);
    end
    chk("wrap fill kept", int'(fill), 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vblank_cmd_scheduler.md
Name: vblank_cmd_scheduler

Overview:
- Buffers drawing/config commands that arrive at any time from the host interface.
- Releases them to the object register file only inside the vertical-blanking window signalled by the VGA timing generator's cmd_en, so visible scan-out never sees mid-frame register changes.
- Enforces a per-frame write budget and provides frame-boundary status.
- Sits between the host command port and the register file, alongside the timing generator.

Parameters:
- CMD_W, 16: command word width (opcode + operand).
- DEPTH, 4: FIFO entries; must be a power of two, at least 2.
- ADDR_W, 2: log2(DEPTH).
- MAX_PER_FRAME, 3: maximum register-file writes per blanking window; range 1..255.

Ports:
- clk  in  1  pixel clock, shared with the timing generator.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_en  in  1  vertical-blank window from the timing generator; high = writes allowed. Glitch-free, registered at source.
- in_valid  in  1  host command valid.
- in_data  in  CMD_W  host command word.
- in_ready  out  1  FIFO can accept a command.
- wr_en  out  1  register-file write strobe, one command per cycle.
- wr_data  out  CMD_W  command word being written (FIFO head).
- frame_start  out  1  one-cycle pulse, registered, on each cmd_en rising edge.
- frame_cnt  out  8  count of blanking windows entered; wraps 255 -> 0.
- fill  out  ADDR_W+1  FIFO occupancy, 0..DEPTH.
- overrun  out  1  sticky: in_valid was seen while in_ready = 0.
- backlog  out  1  sticky: a window ended with the FIFO non-empty.

Behaviour:
- Reset, asynchronous, all registers cleared:
  - FIFO empty, fill = 0, in_ready = 1.
  - state = IDLE, wr_en = 0, wr_data = 0 (head register cleared).
  - frame_start = 0, frame_cnt = 0, overrun = 0, backlog = 0, budget = 0.
  - cmd_en_q resets to 1, so a reset released mid-blank does not drain a partial window. The first drain happens at the next genuine rising edge.
- Edge detect: rise = cmd_en & ~cmd_en_q; cmd_en_q <= cmd_en every cycle.
- FIFO:
  - in_ready = (fill != DEPTH).
  - A push happens when in_valid & in_ready.
  - A pop happens when wr_en.
  - Push and pop in the same cycle: fill unchanged, pointers both advance mod DEPTH.
  - When full, a push is refused even if a pop happens that cycle.
  - Data in is stored in the cycle the push is accepted. wr_data = mem[rd_ptr]; the empty-FIFO contents are don't-care but must be 0 after reset.
- State machine:
  - IDLE: wr_en = 0. On rise, the next state is DRAIN, budget <= 0, frame_start <= 1, frame_cnt <= frame_cnt + 1.
  - DRAIN: wr_en = cmd_en & (fill != 0) & (budget < MAX_PER_FRAME), combinational. Each wr_en increments budget.
    - If cmd_en = 0, next state is IDLE.
    - If budget reaches MAX_PER_FRAME while cmd_en = 1, next state is DONE.
    - An empty FIFO holds DRAIN. Commands pushed during the window are drained the cycle after they are written, within budget.
  - DONE: wr_en = 0. On cmd_en = 0, next state is IDLE.
- First write latency: the earliest wr_en is the cycle after cmd_en rises, since DRAIN is entered on the rise edge.
- backlog: set on the DRAIN/DONE -> IDLE transition if fill != 0 (after that cycle's pop).
- overrun: set when in_valid & ~in_ready.
- frame_start: registered, high for exactly the one cycle after the rise.
- Budget counter width is 8 bits. It saturates at MAX_PER_FRAME.

Decomposition:
- Shared package (gpu_pkg):
  - state enum {IDLE, DRAIN, DONE}.
  - CMD_W default.
  - Command opcode field constants, reused by the register-file decoder.
- One natural sub-module: cmd_fifo, a synchronous circular buffer with async reset. It owns the push/pop/fill logic and the head output.
- The scheduler FSM, edge detect, budget, counters and flags stay in the top.

Test Plan:
- Post-reset idle: rst_n low for 3 cycles, then release with cmd_en = 1 held -> no wr_en until cmd_en goes 0 then 1; frame_cnt = 0 until that rise; in_ready = 1, fill = 0.
- Basic drain: push 0xA001, 0xA002 while cmd_en = 0, then raise cmd_en -> frame_start pulses 1 cycle; wr_en on cycles 1 and 2 after the rise with wr_data 0xA001 then 0xA002; fill returns to 0; frame_cnt = 1.
- Budget limit: push 4 commands (fill = 4, in_ready = 0), hold a 20-cycle window -> exactly 3 writes (FIFO order), state DONE; after cmd_en falls, backlog = 1, fill = 1. The next window writes the 4th command first.
- Overrun and simultaneous push/pop: with fill = 4, assert in_valid -> overrun = 1, fill stays 4. During DRAIN with fill = 2, push on the same cycle as a pop -> fill stays 2 and order is preserved.
- Window cut short: 3 commands queued, cmd_en high for 1 cycle only -> one write at most (0 if the rise cycle only); state IDLE next; backlog = 1.
- Reset mid-drain: assert rst_n low while in DRAIN with fill = 3 -> wr_en drops immediately (async); after release fill = 0, overrun = 0, frame_cnt = 0. Separately, 256 windows -> frame_cnt wraps to 0.
